// File: rtl/piso_shift_tx_if.sv
// Handshake and serial-output bundle for piso_shift_tx.
// The master modport is the word source and line observer; the slave modport is the transmitter.
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din_par;
  logic             load_valid;
  logic             load_ready;
  logic             data_out;
  logic             out_valid;
  logic             frame_start;
  logic             done;

  modport master (
    output din_par, load_valid,
    input  load_ready, data_out, out_valid, frame_start, done
  );

  modport slave (
    input  din_par, load_valid,
    output load_ready, data_out, out_valid, frame_start, done
  );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: MSB-first framing with start and done strobes.
// Optional feature macro PARITY_EN appends one even-parity bit to every frame.
module piso_shift_tx #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  piso_shift_tx_if.slave bus
);

`ifdef PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] load_word;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic             data_q, valid_q, start_q, done_q;
  logic             ready, accept;

  // With parity, the parity bit rides in the vacated LSB and reaches the MSB right after the last data bit.
`ifdef PARITY_EN
  assign load_word = {bus.din_par[WIDTH-2:0], ^bus.din_par};
`else
  assign load_word = bus.din_par << 1;
`endif

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    ready      = 1'b0;
    state_next = state;
    case (state)
      IDLE:    ready = 1'b1;
      SHIFT:   ready = done_q;
      default: ready = 1'b0;
    endcase
    accept = bus.load_valid && ready;
    if (accept)
      state_next = SHIFT;
    else if (state == SHIFT && done_q)
      state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      cnt     <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept) begin
      data_q  <= bus.din_par[WIDTH-1];
      valid_q <= 1'b1;
      start_q <= 1'b1;
      done_q  <= 1'b0;
      shreg   <= load_word;
      cnt     <= CW'(1);
    end else if (state == SHIFT) begin
      if (done_q) begin
        shreg   <= '0;
        cnt     <= '0;
        data_q  <= 1'b0;
        valid_q <= 1'b0;
        start_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        data_q  <= shreg[WIDTH-1];
        shreg   <= shreg << 1;
        cnt     <= cnt_inc;
        start_q <= 1'b0;
        done_q  <= (cnt_inc == CW'(FLEN));
      end
    end
  end

  assign bus.load_ready  = ready;
  assign bus.data_out    = data_q;
  assign bus.out_valid   = valid_q;
  assign bus.frame_start = start_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: directed frame table, corner sequences and a
// randomized run compared against a queue-based frame model. Honours PARITY_EN.
module tb_piso_shift_tx;
  localparam int W = 8;
`ifdef PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  piso_shift_tx_if #(.WIDTH(W)) bus ();

  piso_shift_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic v;
    logic fs;
    logic dn;
  } obs_t;

  typedef struct {
    logic [W-1:0] word;
    logic         par;
  } vec_t;

  obs_t cur;
  obs_t q[$];
  vec_t tbl[8];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] w, input logic p, input int k);
    logic [W-1:0] t;
    t = w;
    if (k < W) return t[W-1-k];
    return p;
  endfunction

  // Reference: on accept the whole frame is queued as per-cycle observations; each edge pops one.
  task automatic tick();
    logic         lv;
    logic [W-1:0] dp;
    obs_t         o;
    @(posedge clk);
    lv = bus.load_valid;
    dp = bus.din_par;
    if (reset) begin
      q.delete();
      cur = '0;
    end else begin
      if (lv && (!cur.v || cur.dn)) begin
        q.delete();
        for (int k = 0; k < FLEN; k++) begin
          o.d  = (k < W) ? dp[W-1-k] : ^dp;
          o.v  = 1'b1;
          o.fs = (k == 0);
          o.dn = (k == FLEN - 1);
          q.push_back(o);
        end
      end
      if (q.size() != 0) cur = q.pop_front();
      else               cur = '0;
    end
    #1;
    chk("model_data",  bus.data_out,    cur.d);
    chk("model_valid", bus.out_valid,   cur.v);
    chk("model_start", bus.frame_start, cur.fs);
    chk("model_done",  bus.done,        cur.dn);
    chk("model_ready", bus.load_ready,  !cur.v || cur.dn);
  endtask

  task automatic cycle(input logic lv, input logic [W-1:0] dp);
    @(negedge clk);
    bus.load_valid = lv;
    bus.din_par    = dp;
    tick();
  endtask

  task automatic send_chk(input logic [W-1:0] word, input logic par);
    cycle(1'b1, word);
    for (int k = 0; k < FLEN; k++) begin
      if (k > 0) cycle(1'b0, W'($urandom));
      chk("frame_data",  bus.data_out,    exp_bit(word, par, k));
      chk("frame_valid", bus.out_valid,   1'b1);
      chk("frame_start", bus.frame_start, k == 0);
      chk("frame_done",  bus.done,        k == FLEN - 1);
      chk("frame_ready", bus.load_ready,  k == FLEN - 1);
    end
    cycle(1'b0, '0);
    chk("after_valid", bus.out_valid, 1'b0);
    chk("after_data",  bus.data_out,  1'b0);
  endtask

  initial begin
    logic [W-1:0] w;
    int           k;
    checks = 0;
    errors = 0;
    cur    = '0;
    reset  = 1'b1;
    bus.load_valid = 1'b0;
    bus.din_par    = '0;

    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h0F, 1'b0};
    tbl[3] = '{8'h81, 1'b0};
    tbl[4] = '{8'h3C, 1'b0};
    tbl[5] = '{8'hFF, 1'b0};
    tbl[6] = '{8'h00, 1'b0};
    tbl[7] = '{8'h80, 1'b1};

    // Reset held for two cycles
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    chk("rst_data",  bus.data_out,    1'b0);
    chk("rst_valid", bus.out_valid,   1'b0);
    chk("rst_start", bus.frame_start, 1'b0);
    chk("rst_done",  bus.done,        1'b0);
    chk("rst_ready", bus.load_ready,  1'b1);
    reset = 1'b0;
    cycle(1'b0, '0);
    chk("post_rst_valid", bus.out_valid, 1'b0);
    chk("post_rst_data",  bus.data_out,  1'b0);
    chk("post_rst_ready", bus.load_ready, 1'b1);

    foreach (tbl[i]) send_chk(tbl[i].word, tbl[i].par);

    // Back-to-back: 3C held valid until taken in the done cycle of A5
    cycle(1'b1, 8'hA5);
    for (int c = 1; c <= 2 * FLEN; c++) begin
      if (c > 1) cycle(c <= FLEN + 1, 8'h3C);
      k = (c - 1) % FLEN;
      w = (c <= FLEN) ? 8'hA5 : 8'h3C;
      chk("b2b_data",  bus.data_out,    exp_bit(w, 1'b0, k));
      chk("b2b_valid", bus.out_valid,   1'b1);
      chk("b2b_start", bus.frame_start, k == 0);
      chk("b2b_done",  bus.done,        k == FLEN - 1);
    end
    cycle(1'b0, '0);
    chk("b2b_end_valid", bus.out_valid, 1'b0);

    // Busy ignore: FF offered while not ready must not be captured
    cycle(1'b1, 8'h0F);
    chk("busy_data", bus.data_out, 1'b0);
    for (int c = 2; c <= FLEN; c++) begin
      cycle(c == 4, (c == 4) ? 8'hFF : 8'h00);
      if (c == 3) chk("busy_ready_c3", bus.load_ready, 1'b0);
      chk("busy_data", bus.data_out, exp_bit(8'h0F, 1'b0, c - 1));
    end
    cycle(1'b0, '0);
    chk("busy_idle_valid", bus.out_valid, 1'b0);
    cycle(1'b0, '0);
    chk("busy_idle_valid2", bus.out_valid, 1'b0);

    // Mid-frame asynchronous reset
    cycle(1'b1, 8'hF0);
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    chk("mid_c3_data", bus.data_out, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    q.delete();
    cur = '0;
    chk("mid_rst_data",  bus.data_out,    1'b0);
    chk("mid_rst_valid", bus.out_valid,   1'b0);
    chk("mid_rst_start", bus.frame_start, 1'b0);
    chk("mid_rst_done",  bus.done,        1'b0);
    chk("mid_rst_ready", bus.load_ready,  1'b1);
    cycle(1'b0, '0);
    reset = 1'b0;
    cycle(1'b0, '0);
    send_chk(8'h81, 1'b0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 79) == 0);
      bus.load_valid = ($urandom_range(0, 3) != 0);
      bus.din_par    = W'($urandom);
      tick();
    end
    @(negedge clk);
    reset = 1'b0;
    bus.load_valid = 1'b0;
    for (int n = 0; n < FLEN + 2; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
